// File: rtl/bin2bcd_disp_feed_if.sv
// Bus between a binary source and the bin2bcd_disp_feed converter.
// master = producer side (drives start/bin/dp_in), slave = converter side.
interface bin2bcd_disp_feed_if #(
    parameter int W = 14
);
    logic         start;
    logic [W-1:0] bin;
    logic [3:0]   dp_in;
    logic         ready;
    logic         done_tick;
    logic [3:0]   hex3;
    logic [3:0]   hex2;
    logic [3:0]   hex1;
    logic [3:0]   hex0;
    logic [3:0]   dp_out;
    logic         overflow;

    modport master (
        output start, bin, dp_in,
        input  ready, done_tick, hex3, hex2, hex1, hex0, dp_out, overflow
    );

    modport slave (
        input  start, bin, dp_in,
        output ready, done_tick, hex3, hex2, hex1, hex0, dp_out, overflow
    );
endinterface

// File: rtl/bin2bcd_disp_feed.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding a 4-digit scanning 7-segment driver. Digits and dp mask are
// registered and only change on the final conversion edge, so the display
// never sees intermediate values.
// Optional feature macro: BIN2BCD_OVF_DISP_EN
//   defined   : bin > 9999 shows "EEEE", dp_out = 0, overflow = 1
//   undefined : bin > 9999 saturates to 9999, overflow tied to 0
// The interface instance must be built with the same W as this module.
module bin2bcd_disp_feed #(
    parameter int W = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    bin2bcd_disp_feed_if.slave   bus
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_OP     = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;
    localparam logic [3:0]  CNT_INIT = 4'(W);
    localparam logic [15:0] MAX_DEC  = 16'd9999;

    logic [1:0]   r_state;
    logic [W-1:0] r_shift;     // binary bits still to be shifted in, MSB first
    logic [15:0]  r_bcd;       // working BCD accumulator, four nibbles
    logic [3:0]   r_count;     // OP edges remaining
    logic [3:0]   r_dp;        // dp mask captured with start
    logic [15:0]  r_digits;    // displayed digits {hex3,hex2,hex1,hex0}
    logic [3:0]   r_dp_out;
`ifdef BIN2BCD_OVF_DISP_EN
    logic         r_ovf_pend;  // range check result captured at the sampling edge
    logic         r_overflow;
`endif

    logic [15:0]  w_bcd_adj;
    logic [15:0]  w_bcd_next;
    logic         w_in_range;
    logic [W-1:0] w_bin_load;
    logic         w_last;

    // Range check is done on the incoming value so latency stays W cycles
    // regardless of the outcome; for W < 14 the value can never exceed 9999.
    assign w_in_range = ({{(16-W){1'b0}}, bus.bin} <= MAX_DEC);

`ifdef BIN2BCD_OVF_DISP_EN
    assign w_bin_load = bus.bin;
`else
    assign w_bin_load = w_in_range ? bus.bin : MAX_DEC[W-1:0];
`endif

    // Add-3 adjust: any nibble >= 5 would exceed 9 after doubling.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                          ? r_bcd[4*gi +: 4] + 4'd3
                                          : r_bcd[4*gi +: 4];
        end
    endgenerate

    // Shift the adjusted BCD left by one, bringing in the next binary MSB.
    // For inputs <= 9999 the thousands digit never carries out.
    assign w_bcd_next = (w_bcd_adj << 1) | {15'd0, r_shift[W-1]};

    assign w_last = (r_state == S_OP) && (r_count == 4'd1);

    // Control FSM and conversion datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_count <= '0;
            r_dp    <= '0;
`ifdef BIN2BCD_OVF_DISP_EN
            r_ovf_pend <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_shift <= w_bin_load;
                        r_dp    <= bus.dp_in;
                        r_bcd   <= '0;
                        r_count <= CNT_INIT;
                        r_state <= S_OP;
`ifdef BIN2BCD_OVF_DISP_EN
                        r_ovf_pend <= !w_in_range;
`endif
                    end
                end
                S_OP: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= r_shift << 1;
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output registers: loaded only on the final OP edge, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits <= '0;
            r_dp_out <= '0;
`ifdef BIN2BCD_OVF_DISP_EN
            r_overflow <= 1'b0;
`endif
        end else if (w_last) begin
`ifdef BIN2BCD_OVF_DISP_EN
            if (r_ovf_pend) begin
                r_digits   <= 16'hEEEE;
                r_dp_out   <= 4'b0000;
                r_overflow <= 1'b1;
            end else begin
                r_digits   <= w_bcd_next;
                r_dp_out   <= r_dp;
                r_overflow <= 1'b0;
            end
`else
            r_digits <= w_bcd_next;
            r_dp_out <= r_dp;
`endif
        end
    end

    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done_tick = (r_state == S_DONE);
    assign bus.hex3      = r_digits[15:12];
    assign bus.hex2      = r_digits[11:8];
    assign bus.hex1      = r_digits[7:4];
    assign bus.hex0      = r_digits[3:0];
    assign bus.dp_out    = r_dp_out;
`ifdef BIN2BCD_OVF_DISP_EN
    assign bus.overflow  = r_overflow;
`else
    assign bus.overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_disp_feed.sv
// Directed testbench for bin2bcd_disp_feed: a W=14 instance for the main
// scenarios and a W=10 instance for the narrow-width case.
module tb_bin2bcd_disp_feed;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bin2bcd_disp_feed_if #(.W(14)) bus14 ();
    bin2bcd_disp_feed_if #(.W(10)) bus10 ();

    bin2bcd_disp_feed #(.W(14)) dut14 (.clk(clk), .reset(reset), .bus(bus14));
    bin2bcd_disp_feed #(.W(10)) dut10 (.clk(clk), .reset(reset), .bus(bus10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One conversion on the W=14 instance. Counts are taken on negedges after
    // the sampling edge; the loop stops one cycle after done_tick.
    task automatic run14(input logic [13:0] v, input logic [3:0] dp,
                         output int done_n, output int rdy_low,
                         output int done_cnt, output int early);
        logic [19:0] old_out;
        old_out  = {bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out};
        done_n   = 0;
        rdy_low  = 0;
        done_cnt = 0;
        early    = 0;
        @(negedge clk);
        bus14.start = 1'b1;
        bus14.bin   = v;
        bus14.dp_in = dp;
        @(negedge clk);
        bus14.start = 1'b0;
        bus14.bin   = ~v;
        bus14.dp_in = ~dp;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (!bus14.ready) rdy_low++;
            if (bus14.done_tick) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end else if (done_n == 0 &&
                         {bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out} !== old_out) begin
                early++;
            end
            if (done_n != 0 && n > done_n) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus14.ready !== 1'b1 || bus14.done_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got ready=%b done=%b want 1 0", bus14.ready, bus14.done_tick);
        end
        checks++;
        if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, bus14.overflow} !== 21'd0) begin
            errors++;
            $display("FAIL reset_out got %h%h%h%h dp=%b ovf=%b want 0000 0000 0",
                     bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, bus14.overflow);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("reset: ready=%b digits=%h%h%h%h", bus14.ready, bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0);
    endtask

    task automatic test_basic;
        int dn, rl, dc, ea;
        run14(14'd1234, 4'b0100, dn, rl, dc, ea);
        $display("basic: bin=1234 -> %h%h%h%h dp=%b done_n=%0d", bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, dn);
        checks++;
        if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0} !== 16'h1234) begin
            errors++;
            $display("FAIL basic_digits got %h%h%h%h want 1234", bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0);
        end
        checks++;
        if (bus14.dp_out !== 4'b0100) begin
            errors++;
            $display("FAIL basic_dp got %b want 0100", bus14.dp_out);
        end
        checks++;
        if (dn !== 15) begin
            errors++;
            $display("FAIL basic_latency got %0d want 15", dn);
        end
        checks++;
        if (rl !== 15) begin
            errors++;
            $display("FAIL basic_ready_low got %0d want 15", rl);
        end
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL basic_done_width got %0d want 1", dc);
        end
        checks++;
        if (ea !== 0) begin
            errors++;
            $display("FAIL basic_early_change got %0d want 0", ea);
        end
    endtask

    task automatic test_edges;
        logic [13:0] vals [3];
        logic [3:0]  dps  [3];
        logic [15:0] exps [3];
        int dn, rl, dc, ea;
        vals[0] = 14'd0;    dps[0] = 4'b0001; exps[0] = 16'h0000;
        vals[1] = 14'd9999; dps[1] = 4'b1000; exps[1] = 16'h9999;
        vals[2] = 14'd1009; dps[2] = 4'b1111; exps[2] = 16'h1009;
        for (int i = 0; i < 3; i++) begin
            run14(vals[i], dps[i], dn, rl, dc, ea);
            $display("edge: bin=%0d -> %h%h%h%h dp=%b", vals[i], bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out);
            checks++;
            if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out} !== {exps[i], dps[i]} || dn !== 15) begin
                errors++;
                $display("FAIL edge_%0d got %h%h%h%h dp=%b lat=%0d want %h dp=%b lat=15", vals[i],
                         bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, dn, exps[i], dps[i]);
            end
        end
    endtask

    task automatic test_overflow;
        int dn, rl, dc, ea;
        logic [15:0] exp_d;
        logic [3:0]  exp_dp;
        logic        exp_ovf;
`ifdef BIN2BCD_OVF_DISP_EN
        exp_d = 16'hEEEE; exp_dp = 4'b0000; exp_ovf = 1'b1;
`else
        exp_d = 16'h9999; exp_dp = 4'b1010; exp_ovf = 1'b0;
`endif
        run14(14'd10000, 4'b1010, dn, rl, dc, ea);
        $display("ovf: bin=10000 -> %h%h%h%h dp=%b ovf=%b", bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, bus14.overflow);
        checks++;
        if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, bus14.overflow} !== {exp_d, exp_dp, exp_ovf}) begin
            errors++;
            $display("FAIL ovf_10000 got %h%h%h%h dp=%b ovf=%b want %h dp=%b ovf=%b",
                     bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, bus14.overflow, exp_d, exp_dp, exp_ovf);
        end
        checks++;
        if (dn !== 15) begin
            errors++;
            $display("FAIL ovf_latency got %0d want 15", dn);
        end
        run14(14'd42, 4'b0000, dn, rl, dc, ea);
        $display("ovf: bin=42 -> %h%h%h%h ovf=%b", bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.overflow);
        checks++;
        if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.overflow} !== {16'h0042, 1'b0}) begin
            errors++;
            $display("FAIL ovf_clear got %h%h%h%h ovf=%b want 0042 ovf=0",
                     bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.overflow);
        end
    endtask

    task automatic test_back_to_back;
        int          vals [0:79];
        logic [3:0]  dpv  [0:79];
        logic [19:0] last_out;
        int          prev_done;
        int          n_done;
        int          bad_gap;
        int          unstable;
        int          seen;
        last_out  = {bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out};
        prev_done = -1;
        n_done    = 0;
        bad_gap   = 0;
        unstable  = 0;
        for (int m = 0; m <= 66; m++) begin
            @(negedge clk);
            if (bus14.done_tick) begin
                n_done++;
                if ((prev_done < 0 && m != 15) || (prev_done >= 0 && m - prev_done != 16)) bad_gap++;
                prev_done = m;
                last_out  = {to_bcd(vals[m-15]), dpv[m-15]};
                $display("b2b: done at %0d bin=%0d -> %h%h%h%h", m, vals[m-15], bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0);
                checks++;
                if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out} !== last_out) begin
                    errors++;
                    $display("FAIL b2b_value got %h%h%h%h dp=%b want %h dp=%b",
                             bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, last_out[19:4], last_out[3:0]);
                end
            end else if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out} !== last_out) begin
                unstable++;
            end
            vals[m] = (m * 797 + 13) % 10000;
            dpv[m]  = 4'(m);
            bus14.start = 1'b1;
            bus14.bin   = 14'(vals[m]);
            bus14.dp_in = dpv[m];
        end
        bus14.start = 1'b0;
        checks++;
        if (n_done !== 4 || bad_gap !== 0) begin
            errors++;
            $display("FAIL b2b_spacing got done=%0d bad_gaps=%0d want 4 0", n_done, bad_gap);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL b2b_stable got %0d changes want 0", unstable);
        end
        // drain the conversion started at the last IDLE cycle
        seen = 0;
        for (int k = 0; k < 40 && !(seen != 0 && bus14.ready); k++) begin
            @(negedge clk);
            if (bus14.done_tick) seen = 1;
        end
        checks++;
        if (bus14.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain got ready=%b want 1", bus14.ready);
        end
    endtask

    task automatic test_reset_mid;
        int dn, rl, dc, ea;
        @(negedge clk);
        bus14.start = 1'b1;
        bus14.bin   = 14'd5678;
        bus14.dp_in = 4'b1001;
        @(negedge clk);
        bus14.start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus14.ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy got ready=%b want 0", bus14.ready);
        end
        #2 reset = 1'b1;
        #1;
        $display("mid_reset: ready=%b digits=%h%h%h%h", bus14.ready, bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0);
        checks++;
        if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, bus14.ready, bus14.done_tick} !== {16'h0000, 4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_async got %h%h%h%h dp=%b ready=%b done=%b want 0000 0000 1 0",
                     bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, bus14.ready, bus14.done_tick);
        end
        @(negedge clk);
        reset = 1'b0;
        run14(14'd5678, 4'b0011, dn, rl, dc, ea);
        $display("mid_reset: rerun bin=5678 -> %h%h%h%h", bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0);
        checks++;
        if ({bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out} !== {16'h5678, 4'b0011} || dn !== 15) begin
            errors++;
            $display("FAIL mid_rerun got %h%h%h%h dp=%b lat=%0d want 5678 dp=0011 lat=15",
                     bus14.hex3, bus14.hex2, bus14.hex1, bus14.hex0, bus14.dp_out, dn);
        end
    endtask

    task automatic test_w10;
        int done_n;
        int early;
        done_n = 0;
        early  = 0;
        @(negedge clk);
        bus10.start = 1'b1;
        bus10.bin   = 10'd1023;
        bus10.dp_in = 4'b0010;
        @(negedge clk);
        bus10.start = 1'b0;
        bus10.bin   = 10'd0;
        for (int n = 1; n <= 30 && done_n == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (bus10.done_tick) done_n = n;
            else if ({bus10.hex3, bus10.hex2, bus10.hex1, bus10.hex0} !== 16'h0000) early++;
        end
        $display("w10: bin=1023 -> %h%h%h%h done_n=%0d", bus10.hex3, bus10.hex2, bus10.hex1, bus10.hex0, done_n);
        checks++;
        if ({bus10.hex3, bus10.hex2, bus10.hex1, bus10.hex0, bus10.dp_out} !== {16'h1023, 4'b0010}) begin
            errors++;
            $display("FAIL w10_digits got %h%h%h%h dp=%b want 1023 dp=0010",
                     bus10.hex3, bus10.hex2, bus10.hex1, bus10.hex0, bus10.dp_out);
        end
        checks++;
        if (done_n !== 11 || early !== 0) begin
            errors++;
            $display("FAIL w10_timing got done_n=%0d early=%0d want 11 0", done_n, early);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus14.start = 1'b0; bus14.bin = '0; bus14.dp_in = '0;
        bus10.start = 1'b0; bus10.bin = '0; bus10.dp_in = '0;
        test_reset();
        test_basic();
        test_edges();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_w10();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
